pio_led: RTL and testbench

- Avalon-MM slave output PIO that drives the board LEDs.
- Write-side counterpart to the switch input PIO; sits on the same system interconnect and uses the same 2-bit-plus address decode style, widened for extra registers.
- Holds a writable data register plus a hardware blink engine, so software can blink selected LEDs without polling.

---
 rtl/pio_led.sv | 134 +++++++++++++
 tb/tb_pio_led.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_led.sv
// -----------------------------------------------------------------------------
// pio_led : Avalon-MM slave output PIO driving the board LEDs, with a
// hardware blink engine so software can blink selected LEDs without polling.
//
// Optional feature macro: PIO_LED_BITSET_EN
//   defined   -> address 4 (OUTSET) ORs writedata into DATA and
//                address 5 (OUTCLEAR) clears writedata bits in DATA.
//   undefined -> addresses 4 and 5 are reserved (writes ignored, read 0).
//
// Register map (word address):
//   0 DATA          r/w
//   1 BLINK_MASK    r/w
//   2 BLINK_PERIOD  r/w  (CNT_WIDTH bits; writing restarts the blink engine)
//   3 OUT_STATUS    r/o  (current out_port)
//   4 OUTSET        w/o, reads 0
//   5 OUTCLEAR      w/o, reads 0
//   6-7 reserved    read 0, writes ignored
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   address     register word address
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data (unused upper bits ignored)
//   readdata    registered read data, zero-extended, one-cycle latency
//   out_port    LED drive: DATA ^ (BLINK_MASK & phase)
// -----------------------------------------------------------------------------
module pio_led #(
    parameter int DATA_WIDTH = 10,
    parameter int CNT_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] data_q,   data_d;
    logic [DATA_WIDTH-1:0] mask_q,   mask_d;
    logic [CNT_WIDTH-1:0]  period_q, period_d;
    logic [CNT_WIDTH-1:0]  cnt_q,    cnt_d;
    logic                  phase_q,  phase_d;
    logic [31:0]           readdata_q, readdata_d;

    logic wr;
    logic unused_wd;

    assign wr = chipselect & ~write_n;

    // Only the low bits of writedata are stored; fold the whole bus here so
    // the ignored upper bits are not flagged as dangling.
    assign unused_wd = &{1'b0, writedata};

    // Register next-state
    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        period_d = period_q;
        if (wr) begin
            case (address)
                3'd0: data_d   = writedata[DATA_WIDTH-1:0];
                3'd1: mask_d   = writedata[DATA_WIDTH-1:0];
                3'd2: period_d = writedata[CNT_WIDTH-1:0];
`ifdef PIO_LED_BITSET_EN
                3'd4: data_d   = data_q | writedata[DATA_WIDTH-1:0];
                3'd5: data_d   = data_q & ~writedata[DATA_WIDTH-1:0];
`endif
                default: ;
            endcase
        end
    end

    // Blink engine: a BLINK_PERIOD write restarts it and takes priority over
    // a terminal count landing on the same edge.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (wr && (address == 3'd2)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period_q) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_ONE;
        end
    end

    assign out_port = data_q ^ (mask_q & {DATA_WIDTH{phase_q}});

    // Read mux is sampled every cycle regardless of chipselect; a read that
    // coincides with a write to the same register therefore sees the old value.
    always_comb begin
        readdata_d = 32'd0;
        case (address)
            3'd0: readdata_d = 32'(data_q);
            3'd1: readdata_d = 32'(mask_q);
            3'd2: readdata_d = 32'(period_q);
            3'd3: readdata_d = 32'(out_port);
            default: readdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= '0;
            mask_q     <= '0;
            period_q   <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_pio_led.sv
// -----------------------------------------------------------------------------
// tb_pio_led : scoreboard bench for pio_led. The driver issues one bus cycle
// per clock, advances a behavioural model and queues the expected readdata
// and out_port for that edge; a separate monitor pops and compares after
// every rising edge.
// -----------------------------------------------------------------------------
module tb_pio_led;

    localparam int DW = 10;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;

    pio_led #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   rd;
        logic [DW-1:0] out;
        int            addr;
        int            txn;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    // Behavioural model: register values plus the number of edges since the
    // blink engine was last restarted (reset or BLINK_PERIOD write).
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_mask;
    logic [CW-1:0] m_period;
    longint        m_k;

    function automatic bit model_phase();
        if (m_period == '0) return 1'b0;
        return ((m_k / (longint'(m_period) + 1)) % 2) == 1;
    endfunction

    function automatic logic [DW-1:0] model_out();
        return model_phase() ? (m_data ^ m_mask) : m_data;
    endfunction

    task automatic bus_cycle(input bit rst, input bit cs, input bit wn,
                             input logic [2:0] a, input logic [31:0] wd);
        exp_t e;
        logic [31:0] dmask;
        logic [31:0] cmask;
        dmask = (32'd1 << DW) - 32'd1;
        cmask = (32'd1 << CW) - 32'd1;
        @(negedge clk);
        reset      = rst;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        txn_no++;
        e.addr = int'(a);
        e.txn  = txn_no;
        case (a)
            3'd0:    e.rd = 32'(m_data);
            3'd1:    e.rd = 32'(m_mask);
            3'd2:    e.rd = 32'(m_period);
            3'd3:    e.rd = 32'(model_out());
            default: e.rd = 32'd0;
        endcase
        if (rst) begin
            m_data   = '0;
            m_mask   = '0;
            m_period = '0;
            m_k      = 0;
            e.rd     = 32'd0;
        end else begin
            if (cs && !wn && a == 3'd2) begin
                m_period = CW'(wd & cmask);
                m_k      = 0;
            end else begin
                m_k++;
                if (cs && !wn) begin
                    case (a)
                        3'd0: m_data = DW'(wd & dmask);
                        3'd1: m_mask = DW'(wd & dmask);
`ifdef PIO_LED_BITSET_EN
                        3'd4: m_data = m_data | DW'(wd & dmask);
                        3'd5: m_data = m_data & ~DW'(wd & dmask);
`endif
                        default: ;
                    endcase
                end
            end
        end
        e.out = model_out();
        q.push_back(e);
        $display("TXN %0d rst=%0b cs=%0b wn=%0b addr=%0d wd=%08h exp_rd=%08h exp_out=%03h",
                 txn_no, rst, cs, wn, a, wd, e.rd, e.out);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
        bus_cycle(1'b0, 1'b1, 1'b0, a, wd);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        bus_cycle(1'b0, 1'b1, 1'b1, a, 32'd0);
    endtask

    // Monitor: readdata and out_port are presented after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (readdata !== e.rd) begin
                    errors++;
                    $display("FAIL readdata txn %0d addr %0d: got %08h want %08h",
                             e.txn, e.addr, readdata, e.rd);
                end
                checks++;
                if (out_port !== e.out) begin
                    errors++;
                    $display("FAIL out_port txn %0d: got %03h want %03h",
                             e.txn, out_port, e.out);
                end
            end
        end
    end

    initial begin
        logic [2:0]  ra;
        logic [31:0] rw;
        int          guard;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        m_data     = '0;
        m_mask     = '0;
        m_period   = '0;
        m_k        = 0;

        // Reset, then every address reads 0
        bus_cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
        bus_cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
        for (int i = 0; i < 8; i++) rd_reg(3'(i));

        // DATA write and readback through DATA and OUT_STATUS
        wr_reg(3'd0, 32'h3A5);
        rd_reg(3'd0);
        rd_reg(3'd3);

        // Blink the low nibble with a 4-cycle half period
        wr_reg(3'd1, 32'h00F);
        wr_reg(3'd0, 32'h000);
        wr_reg(3'd2, 32'd3);
        for (int i = 0; i < 10; i++) rd_reg(3'd3);

        // Restart the engine while phase is 1
        guard = 0;
        while (!model_phase() && guard < 16) begin
            rd_reg(3'd3);
            guard++;
        end
        wr_reg(3'd2, 32'd1);
        for (int i = 0; i < 7; i++) rd_reg(3'd3);

        // Reset mid-blink, then a write coinciding with reset
        bus_cycle(1'b1, 1'b0, 1'b1, 3'd3, 32'd0);
        bus_cycle(1'b1, 1'b1, 1'b0, 3'd0, 32'h155);
        rd_reg(3'd0);

        // Set/clear ports (reserved when the feature is off)
        wr_reg(3'd0, 32'h0F0);
        wr_reg(3'd4, 32'h003);
        rd_reg(3'd0);
        wr_reg(3'd5, 32'h030);
        rd_reg(3'd0);
        rd_reg(3'd4);
        rd_reg(3'd5);

        // Unqualified writes, width truncation, same-cycle write/read
        bus_cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'h155);
        bus_cycle(1'b0, 1'b1, 1'b1, 3'd0, 32'h2AA);
        wr_reg(3'd0, 32'hFFFF_FFFF);
        rd_reg(3'd0);
        wr_reg(3'd2, 32'hFFFF_FFFF);
        rd_reg(3'd2);
        wr_reg(3'd2, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            ra = 3'($urandom_range(0, 7));
            rw = $urandom;
            if (ra == 3'd2) rw = (rw & 32'hFF00_0000) | 32'($urandom_range(0, 6));
            if ($urandom_range(0, 149) == 0)
                bus_cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rw);
            else if ($urandom_range(0, 3) == 0)
                bus_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rw);
            else
                rd_reg(ra);
        end

        // Drain the scoreboard with a bounded wait
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
